// File: rtl/button_debounce_multi.sv
// N-channel push-button conditioner. Each channel synchronises its raw input,
// debounces it with a saturating counter and derives press/release pulses,
// a press-toggled state, and long-press detection with optional auto-repeat.
// Channels share nothing but the clock and reset.
module button_debounce_multi #(
    parameter int N_CH         = 4,
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int LONG_CYC     = 50000000,
    parameter int REPEAT_CYC   = 10000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] button,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] rel_pulse,
    output logic [N_CH-1:0] toggle,
    output logic [N_CH-1:0] long_pulse,
    output logic [N_CH-1:0] long_held,
    output logic [N_CH-1:0] rpt_pulse
);

    localparam int DW = $clog2(DEBOUNCE_CYC);
    localparam int HW = $clog2(LONG_CYC + 1);
    // A zero repeat period still needs a legal (1-bit) counter that stays idle.
    localparam int RW = (REPEAT_CYC > 0) ? $clog2(REPEAT_CYC + 1) : 1;

    localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYC - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYC);
    localparam logic [RW-1:0] RPT_MAX  = RW'(REPEAT_CYC);
    localparam bit            RPT_EN   = (REPEAT_CYC != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        LONG = 2'd2
    } hold_state_t;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic                   btn_norm;
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   sync_in;
            logic [DW-1:0]          deb_cnt_reg;
            logic [DW-1:0]          deb_cnt_next;
            logic                   level_reg;
            logic                   level_next;
            logic                   press_ev;
            logic                   rel_ev;
            logic                   press_reg;
            logic                   rel_reg;
            logic                   toggle_reg;
            hold_state_t            state_reg;
            logic [HW-1:0]          hold_cnt_reg;
            logic [RW-1:0]          rpt_cnt_reg;
            logic                   long_reg;
            logic                   held_reg;
            logic                   rpt_reg;

            // Normalise so that 1 always means pressed.
            assign btn_norm = ACTIVE_LOW ? ~button[gi] : button[gi];
            assign sync_in  = sync_reg[SYNC_STAGES-1];

            // Synchroniser chain; resets to released so reset exit is quiet.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], btn_norm};
                end
            end

            // Debounce decision: any return to the current level restarts the count.
            always_comb begin
                level_next   = level_reg;
                deb_cnt_next = deb_cnt_reg;
                if (sync_in == level_reg) begin
                    deb_cnt_next = '0;
                end else if (deb_cnt_reg == DEB_MAX) begin
                    level_next   = ~level_reg;
                    deb_cnt_next = '0;
                end else begin
                    deb_cnt_next = deb_cnt_reg + DW'(1);
                end
            end

            // Edge events are taken from the level change itself so they line up with it.
            assign press_ev = level_next & ~level_reg;
            assign rel_ev   = ~level_next & level_reg;

            // Debounced level, press/release pulses and press-toggled state.
            always_ff @(posedge clk) begin
                if (rst) begin
                    deb_cnt_reg <= '0;
                    level_reg   <= 1'b0;
                    press_reg   <= 1'b0;
                    rel_reg     <= 1'b0;
                    toggle_reg  <= 1'b0;
                end else begin
                    deb_cnt_reg <= deb_cnt_next;
                    level_reg   <= level_next;
                    press_reg   <= press_ev;
                    rel_reg     <= rel_ev;
                    if (press_ev) begin
                        toggle_reg <= ~toggle_reg;
                    end
                end
            end

            // Hold tracker: long-press detection, then periodic repeat until release.
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg    <= IDLE;
                    hold_cnt_reg <= '0;
                    rpt_cnt_reg  <= '0;
                    long_reg     <= 1'b0;
                    held_reg     <= 1'b0;
                    rpt_reg      <= 1'b0;
                end else begin
                    long_reg <= 1'b0;
                    rpt_reg  <= 1'b0;
                    case (state_reg)
                        IDLE: begin
                            if (press_ev) begin
                                state_reg    <= HOLD;
                                hold_cnt_reg <= HW'(1);
                            end
                        end
                        HOLD: begin
                            // Release takes priority over a long press maturing on the same edge.
                            if (rel_ev) begin
                                state_reg    <= IDLE;
                                hold_cnt_reg <= '0;
                            end else if (hold_cnt_reg == HOLD_MAX) begin
                                state_reg    <= LONG;
                                hold_cnt_reg <= '0;
                                long_reg     <= 1'b1;
                                held_reg     <= 1'b1;
                                rpt_cnt_reg  <= RW'(1);
                            end else begin
                                hold_cnt_reg <= hold_cnt_reg + HW'(1);
                            end
                        end
                        LONG: begin
                            if (rel_ev) begin
                                state_reg   <= IDLE;
                                held_reg    <= 1'b0;
                                rpt_cnt_reg <= '0;
                            end else if (RPT_EN) begin
                                if (rpt_cnt_reg == RPT_MAX) begin
                                    rpt_reg     <= 1'b1;
                                    rpt_cnt_reg <= RW'(1);
                                end else begin
                                    rpt_cnt_reg <= rpt_cnt_reg + RW'(1);
                                end
                            end
                        end
                        default: begin
                            state_reg    <= IDLE;
                            hold_cnt_reg <= '0;
                            rpt_cnt_reg  <= '0;
                            held_reg     <= 1'b0;
                        end
                    endcase
                end
            end

            assign level[gi]       = level_reg;
            assign press_pulse[gi] = press_reg;
            assign rel_pulse[gi]   = rel_reg;
            assign toggle[gi]      = toggle_reg;
            assign long_pulse[gi]  = long_reg;
            assign long_held[gi]   = held_reg;
            assign rpt_pulse[gi]   = rpt_reg;
        end
    endgenerate

endmodule

// File: tb/tb_button_debounce_multi.sv
// Scoreboard bench for button_debounce_multi: stimulus pushes the expected
// pulse events (with their absolute edge number) and a negedge monitor pops
// and compares whenever the DUT shows any pulse.
module tb_button_debounce_multi;

    localparam int N_CH = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N_CH-1:0] button;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] press_pulse;
    logic [N_CH-1:0] rel_pulse;
    logic [N_CH-1:0] toggle;
    logic [N_CH-1:0] long_pulse;
    logic [N_CH-1:0] long_held;
    logic [N_CH-1:0] rpt_pulse;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct packed {
        int         cyc;
        logic [1:0] press;
        logic [1:0] rel;
        logic [1:0] lng;
        logic [1:0] rpt;
        logic [1:0] lvl;
        logic [1:0] tog;
        logic [1:0] held;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        mon_e;
    logic [1:0] tog_model = 2'b00;

    button_debounce_multi #(
        .N_CH        (2),
        .ACTIVE_LOW  (1'b1),
        .SYNC_STAGES (2),
        .DEBOUNCE_CYC(8),
        .LONG_CYC    (40),
        .REPEAT_CYC  (10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .button     (button),
        .level      (level),
        .press_pulse(press_pulse),
        .rel_pulse  (rel_pulse),
        .toggle     (toggle),
        .long_pulse (long_pulse),
        .long_held  (long_held),
        .rpt_pulse  (rpt_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc > 3000) begin
            $display("FAIL watchdog cyc=%0d got no finish, want finish before 3000", cyc);
            $fatal(1);
        end
    end

    // Monitor: every pulse the DUT shows must match the head of the queue.
    always @(negedge clk) begin
        while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
            mon_e = exp_q.pop_front();
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL missed_event got nothing want event at cyc=%0d", mon_e.cyc);
        end
        if (rst === 1'b0 && (|press_pulse || |rel_pulse || |long_pulse || |rpt_pulse)) begin
            total = total + 1;
            if (exp_q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL unexpected_event cyc=%0d got press=%b rel=%b long=%b rpt=%b want none",
                         cyc, press_pulse, rel_pulse, long_pulse, rpt_pulse);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.cyc != cyc || mon_e.press !== press_pulse || mon_e.rel !== rel_pulse ||
                    mon_e.lng !== long_pulse || mon_e.rpt !== rpt_pulse || mon_e.lvl !== level ||
                    mon_e.tog !== toggle || mon_e.held !== long_held) begin
                    bad = bad + 1;
                    $display("FAIL event got cyc=%0d press=%b rel=%b long=%b rpt=%b level=%b toggle=%b held=%b want cyc=%0d press=%b rel=%b long=%b rpt=%b level=%b toggle=%b held=%b",
                             cyc, press_pulse, rel_pulse, long_pulse, rpt_pulse, level, toggle, long_held,
                             mon_e.cyc, mon_e.press, mon_e.rel, mon_e.lng, mon_e.rpt, mon_e.lvl,
                             mon_e.tog, mon_e.held);
                end else begin
                    $display("event cyc=%0d press=%b rel=%b long=%b rpt=%b level=%b toggle=%b held=%b ok",
                             cyc, press_pulse, rel_pulse, long_pulse, rpt_pulse, level, toggle, long_held);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) tick();
    endtask

    // Queue one expected event; toggle model follows presses in push order.
    task automatic push(input int c, input logic [1:0] pr, input logic [1:0] rl,
                        input logic [1:0] lg, input logic [1:0] rp,
                        input logic [1:0] lv, input logic [1:0] hd);
        ev_t e;
        tog_model = tog_model ^ pr;
        e.cyc   = c;
        e.press = pr;
        e.rel   = rl;
        e.lng   = lg;
        e.rpt   = rp;
        e.lvl   = lv;
        e.tog   = tog_model;
        e.held  = hd;
        exp_q.push_back(e);
    endtask

    task automatic check_all_zero(input string name);
        @(negedge clk);
        total = total + 1;
        if ({level, press_pulse, rel_pulse, toggle, long_pulse, long_held, rpt_pulse} !== '0) begin
            bad = bad + 1;
            $display("FAIL %s got level=%b press=%b rel=%b toggle=%b long=%b held=%b rpt=%b want all 0",
                     name, level, press_pulse, rel_pulse, toggle, long_pulse, long_held, rpt_pulse);
        end else begin
            $display("%s cyc=%0d all outputs 0 ok", name, cyc);
        end
    endtask

    initial begin
        int c;
        int p;
        rst    = 1'b1;
        button = 2'b11;
        repeat (3) tick();
        rst = 1'b0;
        check_all_zero("reset_state");
        tick();

        // Clean press and release on channel 0.
        c = cyc;
        button[0] = 1'b0;
        push(c + 10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
        wait_cyc(c + 20);
        button[0] = 1'b1;
        push(c + 30, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        wait_cyc(c + 35);

        // Bounce: low 5, high 2, then held low.
        c = cyc;
        button[0] = 1'b0;
        repeat (5) tick();
        button[0] = 1'b1;
        repeat (2) tick();
        c = cyc;
        button[0] = 1'b0;
        push(c + 10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
        wait_cyc(c + 20);
        button[0] = 1'b1;
        push(c + 30, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        wait_cyc(c + 35);

        // Channel 1 on its own.
        c = cyc;
        button[1] = 1'b0;
        push(c + 10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00);
        wait_cyc(c + 15);
        button[1] = 1'b1;
        push(c + 25, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
        wait_cyc(c + 30);

        // Long press with repeats; release lands on the P+110 repeat edge.
        c = cyc;
        p = c + 10;
        button[0] = 1'b0;
        push(p, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
        push(p + 40, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01);
        for (int k = 1; k <= 6; k++) begin
            push(p + 40 + 10 * k, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01);
        end
        push(p + 110, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        wait_cyc(p + 100);
        button[0] = 1'b1;
        wait_cyc(p + 115);

        // Release so level falls exactly on the long-press edge.
        c = cyc;
        p = c + 10;
        button[0] = 1'b0;
        push(p, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
        push(p + 40, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        wait_cyc(p + 30);
        button[0] = 1'b1;
        wait_cyc(p + 50);

        // Reset while in the long-held state with the button still down.
        c = cyc;
        p = c + 10;
        button[0] = 1'b0;
        push(p, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
        push(p + 40, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01);
        wait_cyc(p + 45);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tog_model = 2'b00;
        push(p + 56, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
        check_all_zero("reset_mid_hold");
        wait_cyc(p + 60);
        button[0] = 1'b1;
        push(p + 70, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        wait_cyc(p + 90);

        // Every queued event must have been seen.
        @(negedge clk);
        total = total + 1;
        if (exp_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL drain got %0d pending events want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
